// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for the burst reader: command, FIFO read port, output stream, status.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [4:0]       len;
    logic             empty;
    logic             R;
    logic [WIDTH-1:0] dataout;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [4:0]       xfer_cnt;

    // Reader view: takes commands, FIFO status/data and stream ready; drives the rest.
    modport slave (
        input  start,
        input  len,
        input  empty,
        input  dataout,
        input  out_ready,
        output R,
        output out_data,
        output out_valid,
        output busy,
        output done,
        output xfer_cnt
    );

    // Environment view: command source, FIFO read port and stream consumer.
    modport master (
        output start,
        output len,
        output empty,
        output dataout,
        output out_ready,
        input  R,
        input  out_data,
        input  out_valid,
        input  busy,
        input  done,
        input  xfer_cnt
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the block-RAM FIFO. Pops exactly len words,
// absorbs the RAM's registered read latency with a small skid buffer, and
// presents the words on a valid/ready stream, pulsing done after the last one.
module fifo_burst_reader #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clkB,
    input  logic               rst,
    fifo_burst_reader_if.slave bus
);
    // Skid buffer must hold every read in flight plus one word being presented
    // and one more so a stalled consumer never forces a read bubble.
    localparam int DEPTH = RD_LAT + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [4:0]       len_reg;
    logic [4:0]       issued_reg;
    logic [4:0]       xfer_cnt_reg;
    logic [2:0]       inflight_reg;
    logic [2:0]       inflight_next;
    logic [2:0]       occ_reg;
    logic [2:0]       occ_next;
    logic [1:0]       wr_ptr_reg;
    logic [1:0]       rd_ptr_reg;
    logic [RD_LAT-1:0] pipe_reg;
    logic [RD_LAT:0]  pipe_ext;
    logic [WIDTH-1:0] buf_reg [DEPTH];

    logic             rd_issue;
    logic             busy_w;
    logic             done_w;
    logic             start_acc;
    logic             push;
    logic             pop;
    logic             out_valid_w;
    logic [3:0]       credit_used;

    // Circular pointer advance for a buffer whose depth need not be a power of two.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Handshake and bookkeeping terms shared by the FSM and the datapath.
    assign start_acc   = (state_reg == IDLE) && bus.start;
    assign out_valid_w = (occ_reg != 3'd0);
    assign pop         = out_valid_w && bus.out_ready;
    assign pipe_ext    = {pipe_reg, rd_issue};
    assign push        = pipe_ext[RD_LAT];
    assign credit_used = {1'b0, inflight_reg} + {1'b0, occ_reg};
    assign occ_next      = occ_reg + {2'b00, push} - {2'b00, pop};
    assign inflight_next = inflight_reg + {2'b00, rd_issue} - {2'b00, push};

    // FSM state register.
    always_ff @(posedge clkB) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: leave FLUSH on the same edge that retires the last word.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issued_reg == len_reg) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if ((inflight_reg == 3'd0) && (occ_next == 3'd0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: read strobe gated by FIFO status, remaining count and buffer credit.
    always_comb begin
        rd_issue = 1'b0;
        busy_w   = 1'b0;
        done_w   = 1'b0;
        case (state_reg)
            RUN: begin
                busy_w   = 1'b1;
                rd_issue = !bus.empty && (issued_reg < len_reg) &&
                           (credit_used < 4'(DEPTH));
            end
            FLUSH: begin
                busy_w = 1'b1;
            end
            DONE: begin
                busy_w = 1'b1;
                done_w = 1'b1;
            end
            default: begin
                busy_w = 1'b0;
            end
        endcase
    end

    // Burst length capture and issued/transferred counters; cleared on an accepted start.
    always_ff @(posedge clkB) begin
        if (rst) begin
            len_reg      <= 5'd0;
            issued_reg   <= 5'd0;
            xfer_cnt_reg <= 5'd0;
        end else if (start_acc) begin
            len_reg      <= bus.len;
            issued_reg   <= 5'd0;
            xfer_cnt_reg <= 5'd0;
        end else begin
            if (rd_issue) begin
                issued_reg <= issued_reg + 5'd1;
            end
            if (pop) begin
                xfer_cnt_reg <= xfer_cnt_reg + 5'd1;
            end
        end
    end

    // Read-valid pipeline: the bit shifted out marks dataout valid this cycle.
    always_ff @(posedge clkB) begin
        if (rst) begin
            pipe_reg     <= '0;
            inflight_reg <= 3'd0;
        end else begin
            pipe_reg     <= pipe_ext[RD_LAT-1:0];
            inflight_reg <= inflight_next;
        end
    end

    // Skid buffer pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clkB) begin
        if (rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            occ_reg    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            occ_reg <= occ_next;
        end
    end

    // Skid buffer storage: each entry loads returning data when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
            always_ff @(posedge clkB) begin
                if (rst) begin
                    buf_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == 2'(gi))) begin
                    buf_reg[gi] <= bus.dataout;
                end
            end
        end
    endgenerate

    assign bus.R         = rd_issue;
    assign bus.out_data  = buf_reg[rd_ptr_reg];
    assign bus.out_valid = out_valid_w;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.xfer_cnt  = xfer_cnt_reg;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: two lanes (RD_LAT=1 and RD_LAT=2) share stimulus,
// each with its own FIFO model and a scoreboard of popped-but-undelivered words.
module tb_fifo_burst_reader;
    localparam int WIDTH = 16;

    logic       clkB = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       out_ready;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [WIDTH-1:0] wr_log [$];
    int         wr_count = 0;
    int         ready_mode = 0;
    int         trickle = 0;
    bit         timed = 1'b0;

    logic [1:0] busy_v;
    logic [1:0] active_v;

    always #5 clkB = ~clkB;
    always @(posedge clkB) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        wr_log.push_back(w);
        wr_count++;
    endtask

    task automatic write_words(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) push_word(base + WIDTH'(i));
    endtask

    task automatic pulse_start(input logic [4:0] l);
        @(posedge clkB); #1;
        start = 1'b1;
        len   = l;
        @(posedge clkB); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != 2'b00 || active_v != 2'b00) && n < 3000) begin
            @(posedge clkB); #1;
            n++;
        end
        check_val("idle_reached", int'(n < 3000), 1);
        repeat (2) @(posedge clkB);
        #1;
    endtask

    // Consumer ready pattern and background FIFO writer.
    always @(posedge clkB) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (trickle > 0 && $urandom_range(0, 1) == 1) begin
            push_word(16'hC000 + WIDTH'(wr_count));
            trickle--;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int LAT = gi + 1;

        fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

        fifo_burst_reader #(.WIDTH(WIDTH), .RD_LAT(LAT)) dut (
            .clkB (clkB),
            .rst  (rst),
            .bus  (bus)
        );

        int               rd_idx = 0;
        logic [WIDTH-1:0] d1 = '0;
        logic [WIDTH-1:0] d2 = '0;
        logic [WIDTH-1:0] popq [$];
        logic [WIDTH-1:0] held = '0;
        bit               rst_seen = 1'b0;
        bit               in_burst = 1'b0;
        bit               stalled = 1'b0;
        bit               busy_drop = 1'b0;
        bit               timed_l = 1'b0;
        int               s_cyc = 0;
        int               exp_len = 0;
        int               burst_x = 0;
        int               r_cnt = 0;
        int               first_r = -1;
        int               first_v = -1;

        assign bus.start     = start;
        assign bus.len       = len;
        assign bus.out_ready = out_ready;
        assign bus.empty     = (rd_idx >= wr_count);
        assign bus.dataout   = (LAT == 1) ? d1 : d2;
        assign busy_v[gi]    = bus.busy;
        assign active_v[gi]  = in_burst;

        // FIFO model with registered read; words popped under reset are lost.
        always @(posedge clkB) begin
            rst_seen <= rst;
            d2 <= d1;
            if (bus.R && !bus.empty) begin
                d1     <= wr_log[rd_idx];
                rd_idx <= rd_idx + 1;
                if (!rst) popq.push_back(wr_log[rd_idx]);
            end
            if (rst) popq.delete();
        end

        // Mid-cycle monitor and scoreboard.
        always @(negedge clkB) begin
            int rel;
            int exp_done;
            rel = cyc - s_cyc;
            if (rst) begin
                in_burst  = 1'b0;
                stalled   = 1'b0;
                busy_drop = 1'b0;
            end else begin
                if (rst_seen) begin
                    check_val("rst_R", bus.R, 0);
                    check_val("rst_out_valid", bus.out_valid, 0);
                    check_val("rst_out_data", bus.out_data, 0);
                    check_val("rst_busy", bus.busy, 0);
                    check_val("rst_done", bus.done, 0);
                    check_val("rst_xfer_cnt", bus.xfer_cnt, 0);
                end
                if (busy_drop) begin
                    check_val("busy_after_done", bus.busy, 0);
                    check_val("done_one_cycle", bus.done, 0);
                    check_val("xfer_cnt_hold", bus.xfer_cnt, exp_len);
                    busy_drop = 1'b0;
                end
                if (stalled) begin
                    check_val("stall_valid", bus.out_valid, 1);
                    check_val("stall_data", bus.out_data, held);
                    stalled = 1'b0;
                end
                if (in_burst) check_val("busy_in_burst", bus.busy, 1);
                if (bus.R) begin
                    check_val("r_while_empty", bus.empty, 0);
                    check_val("r_credit", int'(popq.size() < LAT + 2), 1);
                    check_val("r_in_burst", int'(in_burst), 1);
                    r_cnt++;
                    if (first_r < 0) first_r = rel;
                end
                if (bus.out_valid) begin
                    if (first_v < 0) first_v = rel;
                    if (bus.out_ready) begin
                        check_val("word_expected", int'(popq.size() > 0), 1);
                        if (popq.size() > 0) begin
                            check_val("out_data", bus.out_data, popq[0]);
                            void'(popq.pop_front());
                        end
                        burst_x++;
                    end else begin
                        stalled = 1'b1;
                        held    = bus.out_data;
                    end
                end
                if (bus.done) begin
                    check_val("done_in_burst", int'(in_burst), 1);
                    check_val("burst_words", burst_x, exp_len);
                    check_val("done_xfer_cnt", bus.xfer_cnt, exp_len);
                    check_val("read_count", r_cnt, exp_len);
                    if (timed_l) begin
                        exp_done = (exp_len == 0) ? 1 : exp_len + LAT + 2;
                        check_val("done_cycle", rel, exp_done);
                        if (exp_len > 0) begin
                            check_val("first_r_cycle", first_r, 1);
                            check_val("first_valid_cycle", first_v, LAT + 2);
                        end
                    end
                    $display("lane RD_LAT=%0d: burst len %0d delivered %0d words, done at cycle +%0d",
                             LAT, exp_len, burst_x, rel);
                    in_burst  = 1'b0;
                    busy_drop = 1'b1;
                end
                if (start && !bus.busy) begin
                    in_burst = 1'b1;
                    s_cyc    = cyc;
                    exp_len  = int'(len);
                    burst_x  = 0;
                    r_cnt    = 0;
                    first_r  = -1;
                    first_v  = -1;
                    timed_l  = timed;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 5'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clkB);
        #1 rst = 1'b0;
        repeat (2) @(posedge clkB);
        #1;

        // Nominal burst, FIFO preloaded, ready held high.
        timed = 1'b1; ready_mode = 0;
        write_words(8, 16'hA000);
        pulse_start(5'd8);
        wait_idle();

        // Backpressure with ready pattern 1,0,0,1.
        timed = 1'b0; ready_mode = 1;
        write_words(6, 16'hB000);
        pulse_start(5'd6);
        wait_idle();

        // Empty stall: two words now, two more ten cycles later.
        ready_mode = 0;
        write_words(2, 16'hD000);
        pulse_start(5'd4);
        repeat (10) @(posedge clkB);
        #1;
        write_words(2, 16'hD002);
        wait_idle();

        // Zero length burst.
        timed = 1'b1;
        pulse_start(5'd0);
        wait_idle();

        // Start while busy must be ignored.
        timed = 1'b0; ready_mode = 1;
        write_words(5, 16'hE000);
        pulse_start(5'd5);
        repeat (2) @(posedge clkB);
        pulse_start(5'd2);
        wait_idle();

        // Full-length throughput with the FIFO kept non-empty.
        timed = 1'b1; ready_mode = 0;
        write_words(31, 16'h1000);
        pulse_start(5'd31);
        wait_idle();

        // Reset in cycle 3 of a burst, then a fresh len=3 burst.
        timed = 1'b0; ready_mode = 0;
        write_words(8, 16'h2000);
        pulse_start(5'd8);
        repeat (2) @(posedge clkB);
        #1 rst = 1'b1;
        @(posedge clkB);
        #1 rst = 1'b0;
        pulse_start(5'd3);
        wait_idle();

        // Randomized bursts with random ready and a trickling writer.
        for (int it = 0; it < 24; it++) begin
            int l;
            l = $urandom_range(0, 31);
            ready_mode = 2;
            timed = 1'b0;
            trickle = trickle + l;
            pulse_start(5'(l));
            if (l >= 8 && $urandom_range(0, 2) == 0) begin
                repeat (2) @(posedge clkB);
                pulse_start(5'($urandom_range(0, 31)));
            end
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
